axis_bram_frame_streamer: RTL and testbench

//  Streams frames of words from an external dual-port BRAM read port onto AXI4-Stream.

---
 rtl/axis_bram_frame_streamer.sv | 189 ++++++++++++++++++
 tb/tb_axis_bram_frame_streamer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_frame_streamer.sv
// Streams frames of words from a BRAM read port onto AXI4-Stream, with one-shot/loop/repeat
// modes, graceful stop at frame boundaries and a small output FIFO for full-rate backpressure.
//   state   | meaning
//   S_IDLE  | waiting for a start with a usable config
//   S_RUN   | issuing BRAM reads, frame after frame
//   S_DRAIN | final read issued; emptying pipeline and FIFO
module axis_bram_frame_streamer #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] frame_length,
  input  logic [CNT_WIDTH-1:0]  repeat_count,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  localparam int DEPTH = RD_LATENCY + 2;
  localparam int FW    = DATA_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state;
  logic [1:0]              r_mode;
  logic [ADDR_WIDTH-1:0]   r_start_addr;
  logic [ADDR_WIDTH-1:0]   r_len;
  logic [ADDR_WIDTH-1:0]   r_word_idx;
  logic [CNT_WIDTH-1:0]    r_rep;
  logic [CNT_WIDTH-1:0]    r_frames_issued;
  logic [CNT_WIDTH-1:0]    r_frames_sent;
  logic                    r_stop_req;
  logic                    r_busy;
  logic                    r_done;
  logic [RD_LATENCY-1:0]   r_pipe_vld;
  logic [RD_LATENCY-1:0]   r_pipe_first;
  logic [RD_LATENCY-1:0]   r_pipe_last;
  logic [FW-1:0]           r_fifo [4];
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [2:0]              r_count;

  logic [2:0]              w_inflight;
  logic                    w_issue;
  logic                    w_first;
  logic                    w_last;
  logic                    w_final;
  logic                    w_stop_now;
  logic                    w_start_ok;
  logic                    w_push;
  logic                    w_pop;
  logic [FW-1:0]           w_head;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + {2'b00, r_pipe_vld[i]};
  end

  // Credit check ignores a same-cycle pop, which is why the FIFO holds RD_LATENCY+2 words.
  assign w_issue    = (r_state == S_RUN) &&
                      (({1'b0, r_count} + {1'b0, w_inflight}) < 4'(DEPTH));
  assign w_first    = (r_word_idx == '0);
  assign w_last     = (r_word_idx == (r_len - ADDR_WIDTH'(1)));
  assign w_stop_now = r_stop_req | stop;
  assign w_start_ok = start && (frame_length != '0) && !((mode == 2'd2) && (repeat_count == '0));

  always_comb begin
    case (r_mode)
      2'd1:    w_final = w_last && w_stop_now;
      2'd2:    w_final = w_last && (((r_frames_issued + CNT_WIDTH'(1)) == r_rep) || w_stop_now);
      default: w_final = w_last;
    endcase
  end

  assign bram_en   = w_issue;
  assign bram_addr = r_start_addr + r_word_idx;

  assign w_push        = r_pipe_vld[RD_LATENCY-1];
  assign w_head        = r_fifo[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & w_head[DATA_WIDTH];
  assign m_axis_tuser  = m_axis_tvalid & w_head[DATA_WIDTH+1];
  assign w_pop         = m_axis_tvalid & m_axis_tready;

  assign busy        = r_busy;
  assign done        = r_done;
  assign frames_sent = r_frames_sent;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state         <= S_IDLE;
      r_mode          <= '0;
      r_start_addr    <= '0;
      r_len           <= '0;
      r_rep           <= '0;
      r_word_idx      <= '0;
      r_frames_issued <= '0;
      r_frames_sent   <= '0;
      r_stop_req      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop && m_axis_tlast) r_frames_sent <= r_frames_sent + CNT_WIDTH'(1);
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_mode          <= mode;
            r_start_addr    <= start_addr;
            r_len           <= frame_length;
            r_rep           <= repeat_count;
            r_word_idx      <= '0;
            r_frames_issued <= '0;
            r_frames_sent   <= '0;
            r_stop_req      <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) r_stop_req <= 1'b1;
          if (w_issue) begin
            if (w_last) begin
              r_word_idx      <= '0;
              r_frames_issued <= r_frames_issued + CNT_WIDTH'(1);
              r_stop_req      <= 1'b0;
              if (w_final) r_state <= S_DRAIN;
            end else begin
              r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((r_count == '0) && (w_inflight == '0)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame position tags ride alongside each read so the FIFO entry knows its tuser/tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pipe_vld   <= '0;
      r_pipe_first <= '0;
      r_pipe_last  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_pipe_vld[i]   <= r_pipe_vld[i-1];
        r_pipe_first[i] <= r_pipe_first[i-1];
        r_pipe_last[i]  <= r_pipe_last[i-1];
      end
      r_pipe_vld[0]   <= w_issue;
      r_pipe_first[0] <= w_first;
      r_pipe_last[0]  <= w_last;
      if (w_push) r_wr_ptr <= (r_wr_ptr == 2'(DEPTH - 1)) ? 2'd0 : r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == 2'(DEPTH - 1)) ? 2'd0 : r_rd_ptr + 2'd1;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {r_pipe_first[RD_LATENCY-1], r_pipe_last[RD_LATENCY-1], bram_rddata};
  end

endmodule

// File: tb/tb_axis_bram_frame_streamer.sv
// Bench for axis_bram_frame_streamer: RD_LATENCY=1 and =2 instances share stimulus and are each
// checked every cycle against a word-index model of the expected frame stream.
module tb_axis_bram_frame_streamer;
  localparam int DW = 24;
  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          areset, start, stop, tready;
  logic [1:0]    mode;
  logic [AW-1:0] start_addr, frame_length;
  logic [CW-1:0] repeat_count;

  logic [DW-1:0] tdata [2];
  logic          tvalid [2];
  logic          tlast [2];
  logic          tuser [2];
  logic [AW-1:0] baddr [2];
  logic          ben [2];
  logic [DW-1:0] rdata [2];
  logic          busy [2];
  logic          done [2];
  logic [CW-1:0] fsent [2];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] s1, s2;
    axis_bram_frame_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(g + 1), .CNT_WIDTH(CW)) dut (
      .aclk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode),
      .start_addr(start_addr), .frame_length(frame_length), .repeat_count(repeat_count),
      .m_axis_tdata(tdata[g]), .m_axis_tvalid(tvalid[g]), .m_axis_tlast(tlast[g]),
      .m_axis_tuser(tuser[g]), .m_axis_tready(tready), .bram_addr(baddr[g]), .bram_en(ben[g]),
      .bram_rddata(rdata[g]), .busy(busy[g]), .done(done[g]), .frames_sent(fsent[g]));
    always @(posedge clk) begin
      if (ben[g]) s1 <= memf(baddr[g]);
      s2 <= s1;
    end
    if (g == 0) begin : g_l1
      assign rdata[g] = s1;
    end else begin : g_l2
      assign rdata[g] = s2;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic u; logic l; int c; } ent_t;
  ent_t lg0[$];
  ent_t lg1[$];

  bit  m_act [2];
  int  m_sa [2], m_len [2], m_total [2], m_idx [2], m_frames [2];
  int  first_cyc [2], ndone [2];
  bit  prev_stall [2];
  logic [DW+1:0] prev_word [2];
  bit  pend_start = 0, pend_rst = 0;
  int  p_sa, p_len, p_tot;
  int  ncyc = 0, st_cyc = 0;

  function automatic ent_t lget(input int g, input int i);
    ent_t z;
    z = '{d: '0, u: 1'b0, l: 1'b0, c: -1};
    if (g == 0) begin
      if (i < lg0.size()) z = lg0[i];
    end else begin
      if (i < lg1.size()) z = lg1[i];
    end
    return z;
  endfunction

  function automatic int lsize(input int g);
    return (g == 0) ? lg0.size() : lg1.size();
  endfunction

  // Expected stream: word n is index n%len of frame n/len, read from start+index (mod 2^AW).
  always @(negedge clk) begin : mon
    int k;
    logic [DW+1:0] w, e;
    ent_t en;
    ncyc++;
    for (int g = 0; g < 2; g++) begin
      w = {tuser[g], tlast[g], tdata[g]};
      if (prev_stall[g]) chk($sformatf("hold%0d", g), {tvalid[g], w}, {1'b1, prev_word[g]});
      chk($sformatf("frames_sent%0d", g), fsent[g], CW'(m_frames[g]));
      if (tvalid[g] && first_cyc[g] < 0) first_cyc[g] = ncyc;
      if (tvalid[g] && tready) begin
        if (!m_act[g] || (m_total[g] > 0 && m_idx[g] >= m_total[g] * m_len[g])) begin
          total++;
          bad++;
          $display("FAIL extra_word%0d: got %0h want no word", g, w);
        end else begin
          k = m_idx[g] % m_len[g];
          e = {k == 0, k == m_len[g] - 1, memf(AW'(m_sa[g] + k))};
          chk($sformatf("word%0d_%0d", g, m_idx[g]), w, e);
          if (k == m_len[g] - 1) m_frames[g]++;
          m_idx[g]++;
        end
        en = '{d: tdata[g], u: tuser[g], l: tlast[g], c: ncyc};
        if (g == 0) lg0.push_back(en); else lg1.push_back(en);
      end
      if (done[g]) begin
        ndone[g]++;
        if (m_total[g] > 0) chk($sformatf("end_count%0d", g), m_idx[g], m_total[g] * m_len[g]);
        else                chk($sformatf("end_boundary%0d", g), m_idx[g] % m_len[g], 0);
        m_act[g] = 0;
      end
      prev_stall[g] = tvalid[g] && !tready;
      prev_word[g]  = w;
    end
    if (pend_start) begin
      for (int g = 0; g < 2; g++) begin
        m_act[g] = 1; m_sa[g] = p_sa; m_len[g] = p_len; m_total[g] = p_tot;
        m_idx[g] = 0; m_frames[g] = 0;
      end
      pend_start = 0;
    end
    if (pend_rst) begin
      for (int g = 0; g < 2; g++) begin
        m_act[g] = 0; m_idx[g] = 0; m_frames[g] = 0; prev_stall[g] = 0;
      end
      pend_rst = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] md, input int sa, input int ln, input int rc,
                          input int tot, input bit acc);
    mode = md; start_addr = AW'(sa); frame_length = AW'(ln); repeat_count = CW'(rc);
    start = 1'b1;
    if (acc) begin
      pend_start = 1; p_sa = sa; p_len = ln; p_tot = tot;
      first_cyc[0] = -1; first_cyc[1] = -1; ndone[0] = 0; ndone[1] = 0;
      lg0.delete(); lg1.delete();
    end
    @(posedge clk);
    st_cyc = ncyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < maxc) begin
      step(1);
      n++;
    end
    if (busy[0] || busy[1]) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, want low", nm, maxc);
    end
    step(1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, nu, nl;
    for (int g = 0; g < 2; g++) begin
      m_act[g] = 0; m_sa[g] = 0; m_len[g] = 1; m_total[g] = 0; m_idx[g] = 0; m_frames[g] = 0;
      first_cyc[g] = -1; ndone[g] = 0; prev_stall[g] = 0; prev_word[g] = '0;
    end
    areset = 1; start = 0; stop = 0; mode = 0; start_addr = 0; frame_length = 0;
    repeat_count = 0; tready = 0;
    step(3);
    for (int g = 0; g < 2; g++)
      chk($sformatf("reset_outs%0d", g), {tvalid[g], tlast[g], tuser[g], ben[g], busy[g], done[g], fsent[g]}, '0);
    areset = 0;
    step(1);

    // one-shot, 4 words from 0x010
    tready = 1;
    do_start(2'd0, 'h010, 4, 0, 1, 1);
    wait_idle(50, "oneshot");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("latency%0d", g), first_cyc[g] - st_cyc, g + 3);
      chk($sformatf("os_size%0d", g), lsize(g), 4);
      chk($sformatf("os_w0%0d", g), {lget(g, 0).u, lget(g, 0).l, lget(g, 0).d}, {2'b10, 24'h010FEF});
      chk($sformatf("os_w3%0d", g), {lget(g, 3).u, lget(g, 3).l, lget(g, 3).d}, {2'b01, 24'h013FEC});
      chk($sformatf("os_gap%0d", g), lget(g, 3).c - lget(g, 0).c, 3);
      chk($sformatf("os_done%0d", g), ndone[g], 1);
      chk($sformatf("os_frames%0d", g), fsent[g], 1);
    end

    // address wrap past the top of the BRAM
    do_start(2'd0, 'hFFE, 4, 0, 1, 1);
    wait_idle(50, "wrap");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("wrap_w0_%0d", g), lget(g, 0).d, 24'hFFE001);
      chk($sformatf("wrap_w1_%0d", g), lget(g, 1).d, 24'hFFF000);
      chk($sformatf("wrap_w2_%0d", g), lget(g, 2).d, 24'h000FFF);
      chk($sformatf("wrap_w3_%0d", g), lget(g, 3).d, 24'h001FFE);
    end

    // repeat 3 frames of 5
    do_start(2'd2, 'h200, 5, 3, 3, 1);
    wait_idle(100, "repeat");
    for (int g = 0; g < 2; g++) begin
      nu = 0; nl = 0;
      for (int i = 0; i < lsize(g); i++) begin
        nu += int'(lget(g, i).u);
        nl += int'(lget(g, i).l);
      end
      chk($sformatf("rep_size%0d", g), lsize(g), 15);
      chk($sformatf("rep_gap%0d", g), lget(g, 14).c - lget(g, 0).c, 14);
      chk($sformatf("rep_user_last%0d", g), {nu[7:0], nl[7:0]}, {8'd3, 8'd3});
      chk($sformatf("rep_frames%0d", g), fsent[g], 3);
      chk($sformatf("rep_done%0d", g), ndone[g], 1);
    end

    // loop under random backpressure, then graceful stop
    do_start(2'd1, 'hFF0, 37, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      tready = 1'($urandom_range(0, 1));
      step(1);
    end
    stop = 1;
    step(1);
    stop = 0;
    n = 0;
    while ((busy[0] || busy[1]) && n < 600) begin
      tready = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    tready = 1;
    wait_idle(50, "loop_stop");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("bp_progress%0d", g), fsent[g] > 5, 1);
      chk($sformatf("bp_done%0d", g), ndone[g], 1);
    end

    // stop during word 3 of the second frame; start while busy is ignored
    do_start(2'd1, 'h300, 8, 0, 2, 1);
    n = 0;
    while (m_idx[0] < 11 && n < 100) begin
      step(1);
      n++;
    end
    chk("stop_reach_word", m_idx[0], 11);
    stop = 1;
    step(1);
    stop = 0;
    step(2);
    do_start(2'd0, 'h000, 2, 0, 0, 0);
    wait_idle(100, "stop");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("stop_frames%0d", g), fsent[g], 2);
      chk($sformatf("stop_done%0d", g), ndone[g], 1);
      chk($sformatf("stop_size%0d", g), lsize(g), 16);
    end

    // reset mid-frame under backpressure, then a clean restart
    do_start(2'd1, 'h100, 6, 0, 0, 1);
    step(10);
    tready = 0;
    step(3);
    areset = 1;
    pend_rst = 1;
    step(1);
    for (int g = 0; g < 2; g++)
      chk($sformatf("midreset%0d", g), {tvalid[g], busy[g], fsent[g]}, '0);
    areset = 0;
    step(1);
    tready = 1;
    do_start(2'd0, 'h020, 3, 0, 1, 1);
    wait_idle(50, "restart");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rs_size%0d", g), lsize(g), 3);
      chk($sformatf("rs_w0_%0d", g), {lget(g, 0).u, lget(g, 0).d}, {1'b1, 24'h020FDF});
    end

    // unusable configs leave the block idle
    do_start(2'd0, 'h000, 0, 0, 0, 0);
    step(3);
    for (int g = 0; g < 2; g++) chk($sformatf("len0_busy%0d", g), busy[g], 0);
    do_start(2'd2, 'h000, 4, 0, 0, 0);
    step(3);
    for (int g = 0; g < 2; g++) chk($sformatf("rep0_busy%0d", g), busy[g], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
